// File: rtl/pll_lock_sequencer.sv
// Lock sequencer for a PLL: synchronises and filters LOCK, pulses PLL RESET to (re)acquire lock,
// and releases the downstream reset only after lock has been stable for SETTLE_CYCLES.
module pll_lock_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int DROP_FILTER    = 4,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lock_i,
    input  logic             clear_counts,
    output logic             pll_reset,
    output logic             sys_rst_n,
    output logic             ready,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] relock_count
);

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'b00,
        ST_WAIT_LOCK = 2'b01,
        ST_RUN       = 2'b10,
        ST_LOST      = 2'b11
    } state_t;

    localparam int RST_W  = $clog2(PLL_RST_CYCLES + 1);
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int DROP_W = $clog2(DROP_FILTER + 1);
    localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [DROP_W-1:0] DROP_LAST = DROP_W'(DROP_FILTER - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [RST_W-1:0]       rst_cnt_q, rst_cnt_d;
    logic [SET_W-1:0]       settle_cnt_q, settle_cnt_d;
    logic [TO_W-1:0]        timeout_cnt_q, timeout_cnt_d;
    logic [DROP_W-1:0]      drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]       relock_q, relock_d;
    logic                   lock_s;
    logic                   loss_event;

    // lock_i is asynchronous; nothing but this chain may look at it.
    assign lock_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_PLL_RST;
            sync_q        <= '0;
            rst_cnt_q     <= '0;
            settle_cnt_q  <= '0;
            timeout_cnt_q <= '0;
            drop_cnt_q    <= '0;
            relock_q      <= '0;
        end else begin
            state_q       <= state_d;
            sync_q        <= {sync_q[SYNC_STAGES-2:0], lock_i};
            rst_cnt_q     <= rst_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            relock_q      <= relock_d;
        end
    end

    // Counters idle at zero outside their own state, so every entry starts clean.
    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = '0;
        settle_cnt_d  = '0;
        timeout_cnt_d = '0;
        drop_cnt_d    = '0;
        loss_event    = 1'b0;
        unique case (state_q)
            ST_PLL_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                timeout_cnt_d = timeout_cnt_q + TO_W'(1);
                settle_cnt_d  = lock_s ? settle_cnt_q + SET_W'(1) : '0;
                // Settle completion takes priority over a coincident timeout.
                if (lock_s && (settle_cnt_q == SET_LAST)) begin
                    state_d       = ST_RUN;
                    settle_cnt_d  = '0;
                    timeout_cnt_d = '0;
                end else if (timeout_cnt_q == TO_LAST) begin
                    state_d       = ST_PLL_RST;
                    settle_cnt_d  = '0;
                    timeout_cnt_d = '0;
                end
            end
            ST_RUN: begin
                drop_cnt_d = lock_s ? '0 : drop_cnt_q + DROP_W'(1);
                if (!lock_s && (drop_cnt_q == DROP_LAST)) begin
                    state_d    = ST_LOST;
                    drop_cnt_d = '0;
                    loss_event = 1'b1;
                end
            end
            ST_LOST: begin
                state_d = ST_PLL_RST;
            end
            default: begin
                state_d = ST_PLL_RST;
            end
        endcase
    end

    // A clear coinciding with a loss keeps that loss (result is 1).
    always_comb begin
        relock_d = relock_q;
        if (clear_counts) begin
            relock_d = loss_event ? CNT_W'(1) : '0;
        end else if (loss_event && (relock_q != '1)) begin
            relock_d = relock_q + CNT_W'(1);
        end
    end

    assign pll_reset    = (state_q == ST_PLL_RST);
    assign sys_rst_n    = (state_q == ST_RUN);
    assign ready        = (state_q == ST_RUN);
    assign state_o      = state_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed lock/loss/timeout/saturation/reset scenarios plus
// randomized lock_i segments, all compared every cycle against a phase/elapsed-time model.
module tb_pll_lock_sequencer;

    localparam int SYNC    = 2;
    localparam int SETTLE  = 8;
    localparam int DROP    = 3;
    localparam int PLLR    = 4;
    localparam int TO      = 64;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int M_PLL_RST = 0;
    localparam int M_WAIT    = 1;
    localparam int M_RUN     = 2;
    localparam int M_LOST    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             lock_i;
    logic             clear_counts;
    logic             pll_reset;
    logic             sys_rst_n;
    logic             ready;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] relock_count;

    pll_lock_sequencer #(
        .SYNC_STAGES   (SYNC),
        .SETTLE_CYCLES (SETTLE),
        .DROP_FILTER   (DROP),
        .PLL_RST_CYCLES(PLLR),
        .LOCK_TIMEOUT  (TO),
        .CNT_W         (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lock_i      (lock_i),
        .clear_counts(clear_counts),
        .pll_reset   (pll_reset),
        .sys_rst_n   (sys_rst_n),
        .ready       (ready),
        .state_o     (state_o),
        .relock_count(relock_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase plus elapsed cycles in that phase, and run lengths of synced lock samples.
    int m_phase;
    int m_age;
    int m_hi;
    int m_lo;
    int m_count;
    bit hist[$];   // lock_i as seen at each active edge; lock_s lags by SYNC edges

    task automatic model_reset();
        m_phase = M_PLL_RST;
        m_age   = 0;
        m_hi    = 0;
        m_lo    = 0;
        m_count = 0;
        hist.delete();
        repeat (SYNC) hist.push_back(1'b0);
    endtask

    function automatic bit ls_next();
        return hist[hist.size() - SYNC];
    endfunction

    function automatic bit next_edge_loses();
        return (m_phase == M_RUN) && !ls_next() && (m_lo == DROP - 1);
    endfunction

    task automatic model_edge(input bit lk, input bit clr);
        bit ls;
        bit lost;
        ls   = ls_next();
        lost = 1'b0;
        case (m_phase)
            M_PLL_RST: begin
                m_age++;
                if (m_age == PLLR) begin
                    m_phase = M_WAIT;
                    m_age   = 0;
                    m_hi    = 0;
                end
            end
            M_WAIT: begin
                m_age++;
                m_hi = ls ? m_hi + 1 : 0;
                if (m_hi == SETTLE) begin
                    m_phase = M_RUN;
                    m_lo    = 0;
                end else if (m_age == TO) begin
                    m_phase = M_PLL_RST;
                    m_age   = 0;
                end
            end
            M_RUN: begin
                m_lo = ls ? 0 : m_lo + 1;
                if (m_lo == DROP) begin
                    m_phase = M_LOST;
                    lost    = 1'b1;
                end
            end
            default: begin
                m_phase = M_PLL_RST;
                m_age   = 0;
            end
        endcase
        if (clr)
            m_count = lost ? 1 : 0;
        else if (lost && m_count < CNT_MAX)
            m_count++;
        hist.push_back(lk);
        if (hist.size() > 8) void'(hist.pop_front());
    endtask

    task automatic compare_all();
        check("state",     state_o,      m_phase);
        check("pll_reset", pll_reset,    m_phase == M_PLL_RST);
        check("sys_rst_n", sys_rst_n,    m_phase == M_RUN);
        check("ready",     ready,        m_phase == M_RUN);
        check("relock",    relock_count, m_count);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_edge(lock_i, clear_counts);
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_ready(input string tag, input int bound);
        int n;
        n = 0;
        while (!ready && n < bound) begin
            tick();
            n++;
        end
        check(tag, ready, 1);
    endtask

    task automatic wait_lost(input string tag, input int bound);
        int n;
        n = 0;
        while (state_o != 2'b11 && n < bound) begin
            tick();
            n++;
        end
        check(tag, state_o, 3);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},  state_o,      0);
        check({tag, "_pllrst"}, pll_reset,    1);
        check({tag, "_sysrst"}, sys_rst_n,    0);
        check({tag, "_ready"},  ready,        0);
        check({tag, "_relock"}, relock_count, 0);
    endtask

    // ---------------- stimulus ----------------
    int n;
    int rises[$];
    bit prev;
    int seg_len;
    int kind;

    initial begin
        rst_n        = 1'b0;
        lock_i       = 1'b1;
        clear_counts = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;

        // Start-up with lock already high
        n = 0;
        while (pll_reset && n < 50) begin
            tick();
            n++;
        end
        check("startup_rst_len", n, PLLR);
        check("startup_wait_state", state_o, 1);
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        check("startup_settle_len", n, SETTLE);
        repeat (20) tick();
        check("run_stays_ready", ready, 1);

        // Drop shorter than the filter is invisible
        lock_i = 1'b0;
        repeat (DROP - 1) tick();
        lock_i = 1'b1;
        repeat (6) tick();
        check("short_drop_ready", ready, 1);
        check("short_drop_relock", relock_count, 0);

        // Real loss
        lock_i = 1'b0;
        n = 0;
        while (state_o != 2'b11 && n < 20) begin
            tick();
            n++;
        end
        check("loss_latency", n, SYNC + DROP);
        check("loss_relock", relock_count, 1);
        check("loss_sysrst", sys_rst_n, 0);
        tick();
        check("lost_then_pllrst", state_o, 0);
        n = 0;
        while (pll_reset && n < 50) begin
            tick();
            n++;
        end
        check("relock_rst_len", n, PLLR);

        // Glitch during WAIT_LOCK restarts settling
        lock_i = 1'b1;
        repeat (5) tick();
        lock_i = 1'b0;
        tick();
        lock_i = 1'b1;
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        check("glitch_settle_len", n, SYNC + SETTLE);

        // Lock never returns: periodic PLL reset pulses
        lock_i = 1'b0;
        prev   = pll_reset;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (pll_reset && !prev) rises.push_back(i);
            prev = pll_reset;
        end
        check("timeout_pulse_count", rises.size() >= 3, 1);
        for (int k = 1; k < rises.size(); k++)
            check("timeout_period", rises[k] - rises[k-1], PLLR + TO);
        check("timeout_no_ready", ready, 0);

        // Saturation of the loss counter
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            lock_i = 1'b1;
            wait_ready("sat_ready", 200);
            lock_i = 1'b0;
            wait_lost("sat_lost", 50);
        end
        check("relock_saturated", relock_count, CNT_MAX);

        // Clear coinciding with a loss keeps the loss
        lock_i = 1'b1;
        wait_ready("clr_ready", 200);
        lock_i = 1'b0;
        n = 0;
        while (!next_edge_loses() && n < 20) begin
            tick();
            n++;
        end
        check("clr_predict_reached", next_edge_loses(), 1);
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        check("clr_loss_state", state_o, 3);
        check("clr_loss_relock", relock_count, 1);

        // Plain clear outside a loss
        lock_i = 1'b1;
        wait_ready("clr2_ready", 200);
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        check("clr_plain_relock", relock_count, 0);

        // Asynchronous reset while running
        lock_i = 1'b0;
        wait_lost("arst_pre_lost", 50);
        lock_i = 1'b1;
        wait_ready("arst_ready", 200);
        check("arst_pre_relock", relock_count != 0, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("arst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_values("arst_hold");
        rst_n = 1'b1;

        // Randomized lock_i segments
        for (int s = 0; s < 150; s++) begin
            kind = $urandom_range(0, 9);
            if (kind < 5) begin
                lock_i  = 1'b1;
                seg_len = $urandom_range(5, 40);
            end else if (kind < 8) begin
                lock_i  = 1'b0;
                seg_len = $urandom_range(1, DROP + 1);
            end else begin
                lock_i  = 1'b0;
                seg_len = $urandom_range(20, 90);
            end
            for (int c = 0; c < seg_len; c++) begin
                clear_counts = ($urandom_range(0, 29) == 0);
                tick();
            end
        end
        clear_counts = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
